// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with grant timeout and transaction watchdog.
// Ports: clock/reset, request/grant per master, sampled bus lines
// begin_transaction/end_transaction/busy/error, arbiter-driven
// arb_end_transaction/arb_error, active_master index and bus_idle.
module bus_arbiter #(
  parameter int nrOfMasters  = 4,
  parameter int grantTimeout = 8,
  parameter int busTimeout   = 1023
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [nrOfMasters-1:0] request,
  output logic [nrOfMasters-1:0] grant,
  input  logic                   begin_transaction,
  input  logic                   end_transaction,
  input  logic                   busy,
  input  logic                   error,
  output logic                   arb_end_transaction,
  output logic                   arb_error,
  output logic [2:0]             active_master,
  output logic                   bus_idle
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANTED = 3'd1;
  localparam logic [2:0] S_ACTIVE  = 3'd2;
  localparam logic [2:0] S_TIMEOUT = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [15:0] GT_LAST = 16'(grantTimeout - 1);
  localparam logic [15:0] BT_LAST = 16'(busTimeout - 1);
  localparam logic [2:0]  LAST_RST = 3'(nrOfMasters - 1);
  localparam logic [nrOfMasters-1:0] ONE =
    {{(nrOfMasters-1){1'b0}}, 1'b1};

  logic [2:0]             r_state;
  logic [nrOfMasters-1:0] r_grant;
  logic                   r_arb_end;
  logic                   r_arb_err;
  logic [2:0]             r_active;
  logic [2:0]             r_last;
  logic [15:0]            r_cnt;
  logic                   r_bus_idle;

  logic [2:0] w_win;
  logic       w_any;
  logic       w_hold;

  // Winner = requester with the smallest rotational distance
  // from last+1; distance 0 is the highest priority.
  always_comb begin
    int best;
    int d;
    w_win = '0;
    best  = nrOfMasters;
    d     = 0;
    for (int i = 0; i < nrOfMasters; i++) begin
      d = (i + 2*nrOfMasters - 1 - int'(r_last)) % nrOfMasters;
      if (request[i] && d < best) begin
        best  = d;
        w_win = 3'(i);
      end
    end
  end

  assign w_any  = |request;
  // grant is one-hot on the winner, so this is request[winner].
  assign w_hold = |(request & r_grant);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_arb_end  <= 1'b0;
      r_arb_err  <= 1'b0;
      r_active   <= '0;
      r_last     <= LAST_RST;
      r_cnt      <= '0;
      r_bus_idle <= 1'b1;
    end else begin
      r_arb_end <= 1'b0;
      r_arb_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant    <= ONE << w_win;
            r_active   <= w_win;
            r_cnt      <= '0;
            r_state    <= S_GRANTED;
            r_bus_idle <= 1'b0;
          end
        end
        S_GRANTED: begin
          if (begin_transaction && end_transaction) begin
            r_state <= S_RELEASE;
            r_grant <= '0;
            r_last  <= r_active;
          end else if (begin_transaction) begin
            r_state <= S_ACTIVE;
            r_cnt   <= '0;
          end else if (!w_hold || r_cnt == GT_LAST) begin
            r_state <= S_RELEASE;
            r_grant <= '0;
            r_last  <= r_active;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_ACTIVE: begin
          if (end_transaction || error) begin
            r_state <= S_RELEASE;
            r_grant <= '0;
            r_last  <= r_active;
          end else if (busy) begin
            r_cnt <= r_cnt;
          end else if (r_cnt == BT_LAST) begin
            // Terminate the transaction on behalf of a dead slave.
            r_state   <= S_TIMEOUT;
            r_arb_end <= 1'b1;
            r_arb_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_TIMEOUT: begin
          r_state <= S_RELEASE;
          r_grant <= '0;
          r_last  <= r_active;
        end
        S_RELEASE: begin
          r_state    <= S_IDLE;
          r_bus_idle <= 1'b1;
        end
        default: begin
          r_state    <= S_IDLE;
          r_grant    <= '0;
          r_bus_idle <= 1'b1;
        end
      endcase
    end
  end

  assign grant               = r_grant;
  assign arb_end_transaction = r_arb_end;
  assign arb_error           = r_arb_err;
  assign active_master       = r_active;
  assign bus_idle            = r_bus_idle;

endmodule
